// File: rtl/sprite_line_fetch_pkg.sv
// Shared types and constants for the sprite line fetch stage.
package sprite_line_fetch_pkg;

    localparam int unsigned MAX_SPR_DEFAULT         = 96;
    localparam int unsigned MAP_STRIDE_LOG2_DEFAULT = 6;
    localparam int unsigned TILE_H                  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StCalc,
        StEmit
    } state_t;

    typedef struct packed {
        logic [15:0] map_addr;
        logic [3:0]  row;
        logic [8:0]  spr_num;
        logic [7:0]  yshrink;
    } req_t;

    function automatic logic [5:0] clamp_size(input logic [5:0] size);
        return (size > 6'd32) ? 6'd32 : size;
    endfunction

endpackage

// File: rtl/sprite_vis_calc.sv
// Combinational line-coverage test and tile-map address for one sprite entry.
module sprite_vis_calc
    import sprite_line_fetch_pkg::*;
#(
    parameter int unsigned MAP_STRIDE_LOG2 = MAP_STRIDE_LOG2_DEFAULT
) (
    input  logic [8:0] i_raster,
    input  logic [8:0] i_y,
    input  logic [5:0] i_size,
    input  logic [8:0] i_spr_num,
    input  logic [7:0] i_yshrink,
    output logic       o_visible,
    output req_t       o_req
);

    logic [8:0] w_delta;
    logic [5:0] w_size_c;
    logic [9:0] w_limit;
    logic [4:0] w_tile;

    // Y is stored as an inverted offset, so raster+Y+1 wraps to the line within the sprite.
    assign w_delta  = i_raster + i_y + 9'd1;
    assign w_size_c = clamp_size(i_size);
    assign w_limit  = 10'(w_size_c) * 10'(TILE_H);
    assign w_tile   = w_delta[8:4];

    assign o_visible = (w_size_c != 6'd0) && ({1'b0, w_delta} < w_limit);

    always_comb begin
        o_req          = '0;
        o_req.map_addr = (16'(i_spr_num) << MAP_STRIDE_LOG2) | (16'(w_tile) << 1);
        o_req.row      = w_delta[3:0];
        o_req.spr_num  = i_spr_num;
        o_req.yshrink  = i_yshrink;
    end

endmodule

// File: rtl/sprite_line_fetch.sv
// Walks the per-line active sprite list and emits slow-VRAM tile-map requests for visible sprites.
module sprite_line_fetch
    import sprite_line_fetch_pkg::*;
#(
    parameter int unsigned MAX_SPR         = MAX_SPR_DEFAULT,
    parameter int unsigned MAP_STRIDE_LOG2 = MAP_STRIDE_LOG2_DEFAULT
) (
    input  logic        CLK_24M,
    input  logic        nRESET,
    input  logic        LINE_START,
    input  logic [8:0]  RASTER_LINE,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [8:0]  IN_SPR_NUM,
    input  logic        IN_CHAIN,
    input  logic [8:0]  IN_Y,
    input  logic [5:0]  IN_SIZE,
    input  logic [7:0]  IN_YSHRINK,
    input  logic        LIST_END,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] OUT_MAP_ADDR,
    output logic [3:0]  OUT_ROW,
    output logic [8:0]  OUT_SPR_NUM,
    output logic [7:0]  OUT_YSHRINK,
    output logic [6:0]  SPR_COUNT,
    output logic        LINE_DONE
);

    state_t      r_state, w_state_nxt;
    logic [8:0]  r_raster;
    logic [8:0]  r_chain_y;
    logic [5:0]  r_chain_size;
    logic [7:0]  r_chain_shrink;
    logic [8:0]  r_ent_spr;
    logic [8:0]  r_ent_y;
    logic [5:0]  r_ent_size;
    logic [7:0]  r_ent_shrink;
    req_t        r_req;
    logic [6:0]  r_count;
    logic        r_end;

    logic        w_accept;
    logic        w_in_hs;
    logic        w_out_hs;
    logic        w_done;
    logic        w_visible;
    logic        w_emit;
    req_t        w_req;

    assign w_accept = (r_state == StAccept);
    // An entry offered in the same cycle as LINE_START belongs to the old line and is dropped.
    assign w_in_hs  = w_accept && IN_VALID && !LINE_START;
    assign w_out_hs = (r_state == StEmit) && OUT_READY && !LINE_START;
    assign w_done   = w_accept && r_end && !IN_VALID && !LINE_START;
    assign w_emit   = w_visible && (r_count < 7'(MAX_SPR));

    sprite_vis_calc #(
        .MAP_STRIDE_LOG2 (MAP_STRIDE_LOG2)
    ) u_vis_calc (
        .i_raster  (r_raster),
        .i_y       (r_ent_y),
        .i_size    (r_ent_size),
        .i_spr_num (r_ent_spr),
        .i_yshrink (r_ent_shrink),
        .o_visible (w_visible),
        .o_req     (w_req)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (LINE_START) begin
            w_state_nxt = StAccept;
        end else begin
            unique case (r_state)
                StIdle:   w_state_nxt = StIdle;
                StAccept: begin
                    if (w_in_hs) begin
                        w_state_nxt = StCalc;
                    end else if (w_done) begin
                        w_state_nxt = StIdle;
                    end
                end
                StCalc:   w_state_nxt = w_emit ? StEmit : StAccept;
                StEmit:   w_state_nxt = OUT_READY ? StAccept : StEmit;
                default:  w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            r_raster       <= '0;
            r_chain_y      <= '0;
            r_chain_size   <= '0;
            r_chain_shrink <= '0;
            r_ent_spr      <= '0;
            r_ent_y        <= '0;
            r_ent_size     <= '0;
            r_ent_shrink   <= '0;
            r_req          <= '0;
            r_count        <= '0;
            r_end          <= 1'b0;
        end else if (LINE_START) begin
            r_raster       <= RASTER_LINE;
            r_chain_y      <= '0;
            r_chain_size   <= '0;
            r_chain_shrink <= '0;
            r_count        <= '0;
            r_end          <= 1'b0;
        end else begin
            if (LIST_END) begin
                r_end <= 1'b1;
            end else if (w_done) begin
                r_end <= 1'b0;
            end

            if (w_in_hs) begin
                r_ent_spr <= IN_SPR_NUM;
                if (IN_CHAIN) begin
                    r_ent_y      <= r_chain_y;
                    r_ent_size   <= r_chain_size;
                    r_ent_shrink <= r_chain_shrink;
                end else begin
                    r_ent_y        <= IN_Y;
                    r_ent_size     <= IN_SIZE;
                    r_ent_shrink   <= IN_YSHRINK;
                    r_chain_y      <= IN_Y;
                    r_chain_size   <= IN_SIZE;
                    r_chain_shrink <= IN_YSHRINK;
                end
            end

            if ((r_state == StCalc) && w_emit) begin
                r_req <= w_req;
            end

            if (w_out_hs && (r_count < 7'(MAX_SPR))) begin
                r_count <= r_count + 7'd1;
            end
        end
    end

    assign IN_READY     = w_accept;
    assign OUT_VALID    = (r_state == StEmit);
    assign OUT_MAP_ADDR = r_req.map_addr;
    assign OUT_ROW      = r_req.row;
    assign OUT_SPR_NUM  = r_req.spr_num;
    assign OUT_YSHRINK  = r_req.yshrink;
    assign SPR_COUNT    = r_count;
    assign LINE_DONE    = w_done;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed bench for sprite_line_fetch with a queue-based request scoreboard.
module tb_sprite_line_fetch;

    logic        CLK_24M = 1'b0;
    logic        nRESET = 1'b0;
    logic        LINE_START = 1'b0;
    logic [8:0]  RASTER_LINE = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [8:0]  IN_SPR_NUM = '0;
    logic        IN_CHAIN = 1'b0;
    logic [8:0]  IN_Y = '0;
    logic [5:0]  IN_SIZE = '0;
    logic [7:0]  IN_YSHRINK = '0;
    logic        LIST_END = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [15:0] OUT_MAP_ADDR;
    logic [3:0]  OUT_ROW;
    logic [8:0]  OUT_SPR_NUM;
    logic [7:0]  OUT_YSHRINK;
    logic [6:0]  SPR_COUNT;
    logic        LINE_DONE;

    sprite_line_fetch dut (
        .CLK_24M      (CLK_24M),
        .nRESET       (nRESET),
        .LINE_START   (LINE_START),
        .RASTER_LINE  (RASTER_LINE),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .IN_SPR_NUM   (IN_SPR_NUM),
        .IN_CHAIN     (IN_CHAIN),
        .IN_Y         (IN_Y),
        .IN_SIZE      (IN_SIZE),
        .IN_YSHRINK   (IN_YSHRINK),
        .LIST_END     (LIST_END),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .OUT_MAP_ADDR (OUT_MAP_ADDR),
        .OUT_ROW      (OUT_ROW),
        .OUT_SPR_NUM  (OUT_SPR_NUM),
        .OUT_YSHRINK  (OUT_YSHRINK),
        .SPR_COUNT    (SPR_COUNT),
        .LINE_DONE    (LINE_DONE)
    );

    always #5 CLK_24M = ~CLK_24M;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          n_acc = 0;
    logic [36:0] q[$];
    logic [15:0] last_addr = '0;
    int          m_raster = 0;
    int          m_cy = 0;
    int          m_cs = 0;
    int          m_csh = 0;
    int          m_emitted = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: independent integer arithmetic on each accepted entry.
    task automatic model_entry(input int spr, input bit chain, input int y, input int size,
                               input int shr);
        int delta;
        int sc;
        if (!chain) begin
            m_cy  = y;
            m_cs  = size;
            m_csh = shr;
        end
        delta = (m_raster + m_cy + 1) % 512;
        sc    = (m_cs > 32) ? 32 : m_cs;
        if (sc != 0 && delta < sc * 16 && m_emitted < 96) begin
            q.push_back({16'(spr * 64 + (delta / 16) * 2), 4'(delta % 16), 9'(spr), 8'(m_csh)});
            m_emitted++;
        end
    endtask

    always @(negedge CLK_24M) begin
        logic [36:0] exp_req;
        if (nRESET && OUT_VALID && OUT_READY) begin
            n_out++;
            last_addr = OUT_MAP_ADDR;
            exp_req = (q.size() != 0) ? q.pop_front() : 'x;
            chk("out_req", {OUT_MAP_ADDR, OUT_ROW, OUT_SPR_NUM, OUT_YSHRINK}, exp_req);
        end
    end

    task automatic tick();
        @(posedge CLK_24M);
        #1;
    endtask

    task automatic line_start(input int r);
        LINE_START  = 1'b1;
        RASTER_LINE = 9'(r);
        m_raster    = r;
        m_cy        = 0;
        m_cs        = 0;
        m_csh       = 0;
        m_emitted   = 0;
        tick();
        LINE_START  = 1'b0;
    endtask

    task automatic send(input int spr, input bit chain, input int y, input int size, input int shr);
        int  k;
        bit  ok;
        IN_VALID   = 1'b1;
        IN_SPR_NUM = 9'(spr);
        IN_CHAIN   = chain;
        IN_Y       = 9'(y);
        IN_SIZE    = 6'(size);
        IN_YSHRINK = 8'(shr);
        k  = 0;
        ok = 1'b0;
        while (!ok && k < 20) begin
            @(negedge CLK_24M);
            ok = IN_READY;
            k++;
        end
        chk("in_handshake", ok, 1);
        if (ok) begin
            model_entry(spr, chain, y, size, shr);
            n_acc++;
        end
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            @(negedge CLK_24M);
            k++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int seen;
        int out_before;

        // Reset values
        @(negedge CLK_24M);
        chk("reset_outs", {OUT_VALID, IN_READY, LINE_DONE, SPR_COUNT, OUT_MAP_ADDR, OUT_ROW,
                           OUT_SPR_NUM, OUT_YSHRINK}, 0);
        tick();
        nRESET = 1'b1;
        @(negedge CLK_24M);
        chk("idle_not_ready", IN_READY, 0);
        tick();

        // Basic visible entry and latency
        line_start(10);
        @(negedge CLK_24M);
        chk("accept_ready", IN_READY, 1);
        tick();
        send(5, 0, 9, 2, 8'hAA);
        @(negedge CLK_24M);
        chk("lat_calc_valid", OUT_VALID, 0);
        @(negedge CLK_24M);
        chk("lat_emit_valid", OUT_VALID, 1);
        chk("lat_addr", OUT_MAP_ADDR, 16'h0142);
        chk("lat_row", OUT_ROW, 4);
        @(negedge CLK_24M);
        chk("count_1", SPR_COUNT, 1);
        tick();

        // Invisible entries
        send(6, 0, 9, 0, 0);
        @(negedge CLK_24M);
        chk("size0_calc_ready", IN_READY, 0);
        @(negedge CLK_24M);
        chk("size0_ready_back", IN_READY, 1);
        chk("size0_no_valid", OUT_VALID, 0);
        tick();
        send(7, 0, 100, 1, 0);
        repeat (3) @(negedge CLK_24M);
        chk("invis_count", SPR_COUNT, 1);
        chk("invis_nout", n_out, 1);
        tick();

        // Chain reuse, Y wrap and oversize
        send(1, 0, 0, 4, 8'h11);
        drain();
        chk("chain_head_addr", last_addr, 16'h0040);
        tick();
        send(2, 1, 300, 9, 8'h99);
        drain();
        chk("chain_addr", last_addr, 16'h0080);
        tick();
        send(9, 0, 505, 1, 8'h44);
        drain();
        chk("wrap_addr", last_addr, 16'h0240);
        tick();
        send(10, 0, 500, 40, 8'h66);
        drain();
        chk("oversize_addr", last_addr, 16'h02BE);
        tick();

        // Back-pressure with LIST_END during the stall
        OUT_READY = 1'b0;
        send(3, 0, 20, 8, 8'h33);
        @(negedge CLK_24M);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_24M);
            chk("stall_valid", OUT_VALID, 1);
            chk("stall_in_ready", IN_READY, 0);
            chk("stall_req", {OUT_MAP_ADDR, OUT_ROW, OUT_SPR_NUM, OUT_YSHRINK},
                {16'h00C2, 4'd15, 9'd3, 8'h33});
            chk("stall_no_done", LINE_DONE, 0);
            LIST_END = (i == 1);
        end
        tick();
        OUT_READY = 1'b1;
        @(negedge CLK_24M);
        @(negedge CLK_24M);
        chk("done_pulse", LINE_DONE, 1);
        @(negedge CLK_24M);
        chk("done_cleared", LINE_DONE, 0);
        chk("done_idle", IN_READY, 0);
        chk("line_count", SPR_COUNT, 6);
        tick();

        // Per-line sprite limit
        line_start(0);
        n_out = 0;
        n_acc = 0;
        for (int i = 0; i < 100; i++) begin
            send(i, 0, 0, 1, i);
        end
        drain();
        chk("max_nout", n_out, 96);
        chk("max_count", SPR_COUNT, 96);
        chk("max_consumed", n_acc, 100);
        tick();
        LIST_END = 1'b1;
        tick();
        LIST_END = 1'b0;
        seen = 0;
        for (int k = 0; k < 5 && seen == 0; k++) begin
            @(negedge CLK_24M);
            if (LINE_DONE) seen = 1;
        end
        chk("max_done", seen, 1);
        tick();

        // LINE_START aborts a held request
        line_start(10);
        send(5, 0, 9, 2, 8'h55);
        drain();
        @(negedge CLK_24M);
        chk("abort_pre_count", SPR_COUNT, 1);
        tick();
        OUT_READY = 1'b0;
        send(4, 0, 9, 2, 8'h77);
        @(negedge CLK_24M);
        @(negedge CLK_24M);
        chk("abort_held", OUT_VALID, 1);
        LIST_END = 1'b1;
        tick();
        LIST_END = 1'b0;
        line_start(10);
        q.delete();
        @(negedge CLK_24M);
        chk("abort_valid", OUT_VALID, 0);
        chk("abort_count", SPR_COUNT, 0);
        chk("abort_ready", IN_READY, 1);
        seen = 0;
        repeat (4) begin
            @(negedge CLK_24M);
            if (LINE_DONE) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        OUT_READY = 1'b1;
        tick();
        out_before = n_out;
        send(8, 1, 9, 2, 8'h88);
        repeat (3) @(negedge CLK_24M);
        chk("chain_first_invis", n_out, out_before);
        chk("chain_first_count", SPR_COUNT, 0);
        tick();

        // Asynchronous reset while holding a request
        send(6, 0, 9, 2, 8'h12);
        drain();
        @(negedge CLK_24M);
        chk("rst_pre_count", SPR_COUNT, 1);
        tick();
        OUT_READY = 1'b0;
        send(7, 0, 9, 2, 8'h34);
        @(negedge CLK_24M);
        @(negedge CLK_24M);
        chk("rst_pre_valid", OUT_VALID, 1);
        #2;
        nRESET = 1'b0;
        #1;
        chk("async_reset_outs", {OUT_VALID, IN_READY, LINE_DONE, SPR_COUNT, OUT_MAP_ADDR,
                                 OUT_ROW, OUT_SPR_NUM, OUT_YSHRINK}, 0);
        q.delete();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_line_fetch.md
Name: sprite_line_fetch

Overview:
Sits directly downstream of the fast-VRAM cycle block. It consumes the per-line active sprite list (sprite number, Y, size, Y-shrink and chain bit) one entry at a time. For each entry it computes whether the sprite covers the current raster line, and which tile and row of that sprite apply. Each visible sprite is emitted as a slow-VRAM tile-map address request to the slow-cycle fetch stage. Y-shrink is passed through untouched; the zoom ROM lookup happens downstream.

Parameters:
MAX_SPR, 96, maximum sprites emitted per line; further entries are consumed and dropped.
MAP_STRIDE_LOG2, 6, log2 of slow-VRAM words per sprite tile map (64).

Ports:
CLK_24M  in  1  system clock; all state on its rising edge
nRESET  in  1  asynchronous active-low reset
LINE_START  in  1  one-cycle pulse at start of each line; clears per-line state, highest priority
RASTER_LINE  in  9  current raster line, sampled on LINE_START
IN_VALID  in  1  active-list entry available
IN_READY  out  1  entry accepted when IN_VALID & IN_READY
IN_SPR_NUM  in  9  sprite number
IN_CHAIN  in  1  sticky bit: reuse Y/size/shrink of previous entry
IN_Y  in  9  sprite Y attribute
IN_SIZE  in  6  sprite height in tiles (0 = invisible; >32 clamps to 32)
IN_YSHRINK  in  8  vertical shrink value
LIST_END  in  1  one-cycle pulse: no more entries this line
OUT_VALID  out  1  request valid
OUT_READY  in  1  request accepted when OUT_VALID & OUT_READY
OUT_MAP_ADDR  out  16  tile-map word address
OUT_ROW  out  4  row within tile
OUT_SPR_NUM  out  9  sprite number
OUT_YSHRINK  out  8  shrink value for downstream zoom
SPR_COUNT  out  7  sprites emitted this line, saturates at MAX_SPR
LINE_DONE  out  1  one-cycle pulse when the list is fully processed

Behaviour:
- Reset: FSM=IDLE; all outputs 0; chain registers 0; end flag clear.
- FSM states: IDLE, ACCEPT, CALC, EMIT.
  - IDLE -> ACCEPT on LINE_START.
  - ACCEPT: IN_READY=1. On handshake, latch the entry -> CALC.
  - CALC (1 cycle): compute visibility and address. Visible -> EMIT; invisible -> ACCEPT.
  - EMIT: OUT_VALID=1 and outputs held stable until OUT_READY -> ACCEPT.
- IN_READY is high only in ACCEPT. Latency from input handshake at cycle N to OUT_VALID is N+2 (minimum); back-to-back throughput is 1 entry per 3 cycles.
- Chain handling:
  - IN_CHAIN=0: effective Y/size/shrink come from the entry and are stored in the chain registers.
  - IN_CHAIN=1: effective values come from the chain registers; IN_Y/IN_SIZE/IN_YSHRINK are ignored.
  - Chain registers are cleared on LINE_START, so a chained first entry uses Y=0, size=0 and is invisible.
- Arithmetic:
  - delta[8:0] = (RASTER_LINE + Y_eff + 1) mod 512.
  - size_c = min(size_eff, 32).
  - visible iff size_c != 0 and delta < size_c*16 (10-bit compare).
  - tile = delta[8:4]; OUT_ROW = delta[3:0].
  - OUT_MAP_ADDR = {1'b0, SPR_NUM, tile[4:0], 1'b0}, i.e. SPR_NUM*64 + tile*2.
- Count: SPR_COUNT increments on each output handshake. At MAX_SPR, CALC always treats the entry as invisible (consumed, dropped).
- End of list:
  - LIST_END sets an end flag in any state.
  - When the flag is set and the FSM is in ACCEPT with no handshake that cycle, pulse LINE_DONE, clear the flag, go to IDLE.
  - LIST_END coincident with a handshake: the entry is processed first, then LINE_DONE fires.
- LINE_START mid-operation:
  - Abort: any held output is dropped and OUT_VALID=0 the next cycle.
  - Clear count, end flag and chain registers.
  - Sample RASTER_LINE, enter ACCEPT.
  - No LINE_DONE is issued for the aborted line.
- LINE_START and LIST_END in the same cycle: LINE_START wins and LIST_END is ignored.

Decomposition:
- Shared package: state enum, MAX_SPR default, the tile-height constant (16), and a request struct (map_addr, row, spr_num, yshrink).
- One sub-module is natural: sprite_vis_calc, a combinational delta/visibility/address computation registered at the end of CALC.

Test Plan:
- LINE_START with RASTER_LINE=10; entry spr=5, Y=9, size=2, chain=0 -> delta=20, OUT_MAP_ADDR=0x0142 (5*64+1*2), OUT_ROW=4, OUT_VALID at handshake+2, SPR_COUNT=1.
- Same line, entry size=0 -> no OUT_VALID, IN_READY back high 2 cycles after the handshake; then Y=100, size=1 (delta=111) -> invisible.
- Chain sequence: spr=1 Y=0 size=4, then spr=2 chain=1 with IN_Y=300 -> spr 2 uses Y=0, OUT_MAP_ADDR=0x0080+tile*2.
- Hold OUT_READY low 5 cycles in EMIT -> outputs stable and IN_READY low throughout; assert LIST_END during this -> LINE_DONE one cycle after the EMIT handshake returns the FSM to ACCEPT.
- MAX_SPR=96: feed 100 visible entries -> exactly 96 outputs, SPR_COUNT=96, all 100 consumed.
- LINE_START while in EMIT -> OUT_VALID=0 next cycle, SPR_COUNT=0, no LINE_DONE; assert nRESET mid-line -> all outputs 0 immediately (asynchronous).
